mem_bus_scheduler: RTL and testbench
====================================

MEM_BUS_SCHEDULER -- requirements
Module: mem_bus_scheduler

Interface
REQ-001 Parameter: WIDTH, 32, data/address width.
REQ-002 Parameter: STARVE_LIM, 8, consecutive non-fetch grants tolerated while fetch waits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 f_req  in  1  fetch read request; held until f_done or withdrawn on flush.
REQ-006 f_addr  in  WIDTH  fetch address.
REQ-007 d_req, d_we  in  1 each  data-stage request and write enable (0 = load).
REQ-008 d_sel  in  2  access size: 00 byte, 01 half, 10 word.
REQ-009 d_addr, d_wdata  in  WIDTH each  data-stage address and store data.
REQ-010 x_req, x_we, x_sel, x_addr, x_wdata  in  1/1/2/WIDTH/WIDTH  external loader/debug port, same meaning as d_*.
REQ-011 flush  in  1  pipeline redirect (jump taken); kills outstanding fetch.
REQ-012 m_rdata  in  WIDTH  memory read data; m_wait  in  1  memory not ready.
REQ-013 m_addr, m_wdata  out  WIDTH each; m_we, m_re  out  1 each; m_sel  out  2.
REQ-014 f_done, d_done, x_done  out  1 each  one-cycle completion pulses.
REQ-015 rdata  out  WIDTH  registered read data, valid during any *_done pulse; busy  out  1  state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, RESP.
REQ-017 In IDLE or RESP, with any eligible request, the block SHALL latch the winner's addr/we/sel/wdata and enter BUSY next cycle; otherwise go/stay IDLE.
REQ-018 Fixed priority SHALL be D > X > F, except when the starvation counter equals STARVE_LIM and f_req is high, in which case F wins.
REQ-019 The 3-bit-plus starvation counter SHALL increment on each D or X grant while f_req is high, clear on F grant or when f_req is low, and saturate at STARVE_LIM.
REQ-020 In BUSY, m_addr/m_sel/m_wdata SHALL drive the latched values; m_re = ~we, m_we = we; F grants SHALL always be reads with m_sel = 10.
REQ-021 In BUSY, if m_wait = 0 at the edge, the block SHALL capture m_rdata into rdata (reads only; rdata holds on writes) and enter RESP; if m_wait = 1, remain in BUSY with outputs stable.
REQ-022 In RESP, the owner's *_done SHALL be high for exactly that cycle; m_re and m_we SHALL be 0.
REQ-023 In RESP, the current owner's req SHALL be ignored for arbitration; other requests MAY be granted, giving minimum 3-cycle transaction spacing per requester and 2-cycle back-to-back between different requesters.
REQ-024 flush in IDLE/RESP SHALL block an F grant that cycle; flush while F owns BUSY SHALL set a kill flag so the memory access completes but f_done is suppressed in RESP.
REQ-025 flush while D or X owns the bus SHALL have no effect.
REQ-026 A request withdrawn before grant SHALL not be served; requests are not withdrawn after grant except F via flush.
REQ-027 Latency from req (in IDLE, m_wait = 0) to done SHALL be 2 cycles.

Reset
REQ-028 On rst low, immediately: state IDLE, m_we = m_re = 0, m_addr = m_wdata = 0, m_sel = 00, all *_done = 0, rdata = 0, kill flag = 0, starvation counter = 0.
REQ-029 Reset mid-BUSY SHALL abandon the transaction with no done pulse; operation resumes on the first edge after rst rises.

Structure
REQ-030 FSM state encoding, owner encoding (F/D/X), and sel codes SHALL live in a shared package (cpu_pkg).
REQ-031 Priority-plus-starvation selection SHALL be one combinational sub-module, bus_prio_sel.

Verification
REQ-032 Single fetch: f_req=1, f_addr=0x100, m_wait=0, m_rdata=0xDEADBEEF -> m_re at cycle 1, f_done and rdata=0xDEADBEEF at cycle 2.
REQ-033 Contention: f_req and d_req (store 0x55 to 0x200, sel 00) together -> D served first (m_we=1, m_sel=00), F granted from D's RESP cycle.
REQ-034 Wait states: d_req load, m_wait high 3 cycles -> BUSY held 4 cycles with stable m_addr, d_done 1 cycle after m_wait drops.
REQ-035 Flush: F in BUSY, flush pulse, m_wait=1 -> access completes, no f_done, next grant follows normally.
REQ-036 Starvation: f_req held, d_req/x_req continuously asserted -> after 8 D/X grants, F granted next.
REQ-037 Reset mid-BUSY: assert rst while m_re=1 -> m_re drops same cycle, no done, busy=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory bus scheduler: FSM states, bus owners, access sizes.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_D    = 2'd2,
      OWN_X    = 2'd3
   } owner_t;

   localparam logic [1:0] SEL_BYTE = 2'b00;
   localparam logic [1:0] SEL_HALF = 2'b01;
   localparam logic [1:0] SEL_WORD = 2'b10;

endpackage

// File: rtl/bus_prio_sel.sv
// Combinational bus winner select: D > X > F, F forced once the starvation count hits its limit.
// Zero latency; requesters are expected to be pre-masked for eligibility by the caller.
module bus_prio_sel
   import cpu_pkg::*;
#(
   parameter int STARVE_LIM = 8,
   parameter int CW         = 4
)(
   input  logic          f_elig,
   input  logic          d_elig,
   input  logic          x_elig,
   input  logic [CW-1:0] starve_cnt,
   output logic          grant_vld,
   output owner_t        grant_own
);

   logic starved;

   assign starved = (starve_cnt == CW'(STARVE_LIM));

   always_comb begin
      grant_vld = f_elig | d_elig | x_elig;
      grant_own = OWN_NONE;
      if (f_elig && starved) begin
         grant_own = OWN_F;
      end else if (d_elig) begin
         grant_own = OWN_D;
      end else if (x_elig) begin
         grant_own = OWN_X;
      end else if (f_elig) begin
         grant_own = OWN_F;
      end
   end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Single-port memory arbiter for fetch, data and external ports; IDLE -> BUSY -> RESP, done 2 cycles after grant.
// m_wait stretches BUSY with stable outputs; a flushed fetch completes on the bus but its done is suppressed.
module mem_bus_scheduler
   import cpu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int STARVE_LIM = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             f_req,
   input  logic [WIDTH-1:0] f_addr,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [1:0]       d_sel,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   input  logic             x_req,
   input  logic             x_we,
   input  logic [1:0]       x_sel,
   input  logic [WIDTH-1:0] x_addr,
   input  logic [WIDTH-1:0] x_wdata,
   input  logic             flush,
   input  logic [WIDTH-1:0] m_rdata,
   input  logic             m_wait,
   output logic [WIDTH-1:0] m_addr,
   output logic [WIDTH-1:0] m_wdata,
   output logic             m_we,
   output logic             m_re,
   output logic [1:0]       m_sel,
   output logic             f_done,
   output logic             d_done,
   output logic             x_done,
   output logic [WIDTH-1:0] rdata,
   output logic             busy
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   bus_state_t    state;
   owner_t        owner;
   logic          kill;
   logic [CW-1:0] starve_cnt;

   logic   arb_en;
   logic   f_elig;
   logic   d_elig;
   logic   x_elig;
   logic   grant_vld;
   owner_t grant_own;

   // The owner finishing in RESP may not re-win immediately, enforcing 3-cycle spacing per requester.
   assign arb_en = (state != ST_BUSY);
   assign f_elig = arb_en && f_req && !flush && !(state == ST_RESP && owner == OWN_F);
   assign d_elig = arb_en && d_req && !(state == ST_RESP && owner == OWN_D);
   assign x_elig = arb_en && x_req && !(state == ST_RESP && owner == OWN_X);
   assign busy   = (state != ST_IDLE);

   bus_prio_sel #(
      .STARVE_LIM (STARVE_LIM),
      .CW         (CW)
   ) u_prio_sel (
      .f_elig     (f_elig),
      .d_elig     (d_elig),
      .x_elig     (x_elig),
      .starve_cnt (starve_cnt),
      .grant_vld  (grant_vld),
      .grant_own  (grant_own)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         kill       <= 1'b0;
         starve_cnt <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_we       <= 1'b0;
         m_re       <= 1'b0;
         m_sel      <= SEL_BYTE;
         f_done     <= 1'b0;
         d_done     <= 1'b0;
         x_done     <= 1'b0;
         rdata      <= '0;
      end else begin
         f_done <= 1'b0;
         d_done <= 1'b0;
         x_done <= 1'b0;

         if (!f_req || (grant_vld && grant_own == OWN_F)) begin
            starve_cnt <= '0;
         end else if (grant_vld && starve_cnt != CW'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CW'(1);
         end

         case (state)
            ST_IDLE, ST_RESP: begin
               m_re <= 1'b0;
               m_we <= 1'b0;
               if (grant_vld) begin
                  state <= ST_BUSY;
                  owner <= grant_own;
                  kill  <= 1'b0;
                  case (grant_own)
                     OWN_F: begin
                        m_addr  <= f_addr;
                        m_wdata <= '0;
                        m_sel   <= SEL_WORD;
                        m_re    <= 1'b1;
                     end
                     OWN_D: begin
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_sel   <= d_sel;
                        m_we    <= d_we;
                        m_re    <= ~d_we;
                     end
                     OWN_X: begin
                        m_addr  <= x_addr;
                        m_wdata <= x_wdata;
                        m_sel   <= x_sel;
                        m_we    <= x_we;
                        m_re    <= ~x_we;
                     end
                     default: begin
                     end
                  endcase
               end else begin
                  state <= ST_IDLE;
                  owner <= OWN_NONE;
               end
            end
            ST_BUSY: begin
               if (flush && owner == OWN_F) begin
                  kill <= 1'b1;
               end
               if (!m_wait) begin
                  state <= ST_RESP;
                  m_re  <= 1'b0;
                  m_we  <= 1'b0;
                  if (!m_we) begin
                     rdata <= m_rdata;
                  end
                  // A flush landing on the completing edge must also suppress the fetch done.
                  case (owner)
                     OWN_F:   f_done <= !(kill || flush);
                     OWN_D:   d_done <= 1'b1;
                     OWN_X:   x_done <= 1'b1;
                     default: begin
                     end
                  endcase
               end
            end
            default: begin
               state <= ST_IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Bench for mem_bus_scheduler: directed transactions with a done-pulse scoreboard and cycle-level bus checks.
module tb_mem_bus_scheduler;

   localparam int          WIDTH = 32;
   localparam logic [31:0] KEY   = 32'hA5C3_0F0F;

   typedef struct packed {
      logic [2:0]  own;
      logic [31:0] rd;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             f_req;
   logic [WIDTH-1:0] f_addr;
   logic             d_req, d_we;
   logic [1:0]       d_sel;
   logic [WIDTH-1:0] d_addr, d_wdata;
   logic             x_req, x_we;
   logic [1:0]       x_sel;
   logic [WIDTH-1:0] x_addr, x_wdata;
   logic             flush;
   logic [WIDTH-1:0] m_rdata;
   logic             m_wait;
   logic [WIDTH-1:0] m_addr, m_wdata;
   logic             m_we, m_re;
   logic [1:0]       m_sel;
   logic             f_done, d_done, x_done;
   logic [WIDTH-1:0] rdata;
   logic             busy;

   logic             rd_force_en;
   logic [31:0]      rd_force_val;

   exp_t sb_q[$];
   exp_t sb_e;
   int   n_cmp = 0;
   int   n_err = 0;
   logic found;

   always #5 clk = ~clk;

   // Memory model: read data is a keyed function of the address unless overridden.
   assign m_rdata = rd_force_en ? rd_force_val : (m_addr ^ KEY);

   mem_bus_scheduler #(.WIDTH(WIDTH), .STARVE_LIM(8)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
      .x_req(x_req), .x_we(x_we), .x_sel(x_sel), .x_addr(x_addr), .x_wdata(x_wdata),
      .flush(flush), .m_rdata(m_rdata), .m_wait(m_wait),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_sel(m_sel),
      .f_done(f_done), .d_done(d_done), .x_done(x_done),
      .rdata(rdata), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && (f_done | d_done | x_done)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", {29'd0, x_done, d_done, f_done}, 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_owner", {29'd0, x_done, d_done, f_done}, {29'd0, sb_e.own});
            chk("sb_rdata", rdata, sb_e.rd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      f_req = 0; f_addr = '0;
      d_req = 0; d_we = 0; d_sel = 2'b00; d_addr = '0; d_wdata = '0;
      x_req = 0; x_we = 0; x_sel = 2'b00; x_addr = '0; x_wdata = '0;
      flush = 0; m_wait = 0; rd_force_en = 0; rd_force_val = '0;
      #1;
      chk("rst_m_re", m_re, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_sel", m_sel, 0);
      chk("rst_dones", {f_done, d_done, x_done}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_busy", busy, 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Single fetch, 2-cycle latency
      rd_force_en = 1; rd_force_val = 32'hDEAD_BEEF;
      f_req = 1; f_addr = 32'h100;
      sb_q.push_back({3'b001, 32'hDEAD_BEEF});
      tick();
      chk("t1_m_re", m_re, 1);
      chk("t1_m_addr", m_addr, 32'h100);
      chk("t1_m_sel", m_sel, 2'b10);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_f_done", f_done, 1);
      chk("t1_rdata", rdata, 32'hDEAD_BEEF);
      chk("t1_resp_m_re", m_re, 0);
      f_req = 0; rd_force_en = 0;
      tick();
      chk("t1_idle", busy, 0);

      // Contention: D store wins, F granted from D's RESP
      f_req = 1; f_addr = 32'h300;
      d_req = 1; d_we = 1; d_sel = 2'b00; d_addr = 32'h200; d_wdata = 32'h55;
      sb_q.push_back({3'b010, 32'hDEAD_BEEF});
      sb_q.push_back({3'b001, 32'h300 ^ KEY});
      tick();
      chk("t2_d_we", m_we, 1);
      chk("t2_d_re", m_re, 0);
      chk("t2_d_sel", m_sel, 2'b00);
      chk("t2_d_addr", m_addr, 32'h200);
      chk("t2_d_wdata", m_wdata, 32'h55);
      tick();
      chk("t2_d_done", d_done, 1);
      chk("t2_resp_we", m_we, 0);
      d_req = 0;
      tick();
      chk("t2_f_re", m_re, 1);
      chk("t2_f_addr", m_addr, 32'h300);
      tick();
      chk("t2_f_done", f_done, 1);
      f_req = 0;
      tick();

      // Wait states on a D load; flush meanwhile must not matter
      m_wait = 1;
      d_req = 1; d_we = 0; d_sel = 2'b10; d_addr = 32'h400;
      sb_q.push_back({3'b010, 32'h400 ^ KEY});
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t3_hold_re", m_re, 1);
         chk("t3_hold_addr", m_addr, 32'h400);
         chk("t3_no_done", d_done, 0);
         flush = (i == 1);
         if (i == 3) m_wait = 0;
         tick();
      end
      chk("t3_d_done", d_done, 1);
      chk("t3_rdata", rdata, 32'h400 ^ KEY);
      d_req = 0;
      tick();

      // Flush: blocks F grant in IDLE, kills f_done when F owns BUSY
      f_req = 1; f_addr = 32'h500; flush = 1;
      tick();
      chk("t4_flush_block", busy, 0);
      flush = 0; m_wait = 1;
      tick();
      chk("t4_f_re", m_re, 1);
      chk("t4_f_addr", m_addr, 32'h500);
      flush = 1;
      tick();
      flush = 0; f_req = 0;
      chk("t4_kill_hold", m_re, 1);
      m_wait = 0;
      tick();
      chk("t4_no_f_done", f_done, 0);
      chk("t4_resp_busy", busy, 1);
      chk("t4_resp_re", m_re, 0);
      chk("t4_rdata", rdata, 32'h500 ^ KEY);
      tick();
      f_req = 1; f_addr = 32'h504;
      sb_q.push_back({3'b001, 32'h504 ^ KEY});
      tick();
      chk("t4_next_addr", m_addr, 32'h504);
      chk("t4_next_re", m_re, 1);
      tick();
      chk("t4_next_done", f_done, 1);
      f_req = 0;
      tick();

      // Starvation: 8 alternating D/X grants, then F
      f_req = 1; f_addr = 32'h600;
      d_req = 1; d_we = 0; d_sel = 2'b10; d_addr = 32'h700;
      x_req = 1; x_we = 0; x_sel = 2'b10; x_addr = 32'h800;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) sb_q.push_back({3'b010, 32'h700 ^ KEY});
         else            sb_q.push_back({3'b100, 32'h800 ^ KEY});
      end
      sb_q.push_back({3'b001, 32'h600 ^ KEY});
      found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         tick();
         if (m_re && m_addr == 32'h600) found = 1;
      end
      d_req = 0; x_req = 0;
      chk("t5_starve_grant", found, 1);
      tick();
      chk("t5_f_done", f_done, found);
      f_req = 0;
      tick();
      chk("t5_sb_drain", 32'(sb_q.size()), 0);

      // Reset mid-BUSY abandons the access
      m_wait = 1;
      d_req = 1; d_we = 0; d_sel = 2'b10; d_addr = 32'h880;
      tick();
      chk("t6_pre_re", m_re, 1);
      rst = 0;
      #1;
      chk("t6_re_drop", m_re, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", {f_done, d_done, x_done}, 0);
      chk("t6_rdata", rdata, 0);
      chk("t6_addr", m_addr, 0);
      d_req = 0; m_wait = 0;
      tick(); tick();
      rst = 1;
      tick();
      chk("t6_post_idle", busy, 0);

      // X store after reset: rdata holds its cleared value
      x_req = 1; x_we = 1; x_sel = 2'b01; x_addr = 32'h900; x_wdata = 32'hCAFE;
      sb_q.push_back({3'b100, 32'h0});
      tick();
      chk("t7_x_we", m_we, 1);
      chk("t7_x_re", m_re, 0);
      chk("t7_x_sel", m_sel, 2'b01);
      chk("t7_x_wdata", m_wdata, 32'hCAFE);
      tick();
      chk("t7_x_done", x_done, 1);
      x_req = 0;
      tick(); tick();
      chk("sb_final_drain", 32'(sb_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
